branch_predictor_param: RTL and testbench

BRANCH_PREDICTOR_PARAM -- requirements
Module: branch_predictor_param

---
 rtl/branch_predictor_param.sv | 121 ++++++++++++
 tb/tb_branch_predictor_param.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_param.sv
// Direct-mapped branch predictor with saturating counters and stage-3 mispredict correction.
// Optional performance counters are enabled by defining BRANCH_PREDICTOR_PERF_EN.
module branch_predictor_param #(
    parameter int unsigned ENTRIES = 32,
    parameter int unsigned CNT_W   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memory_stall,
    input  logic [31:0] instructionPC_1,
    output logic        taken,
    output logic [31:0] branchPC,
    output logic        flush,
    input  logic [31:0] instructionPC_3,
    input  logic        is_branchInst_3,
    input  logic        taken_3,
    input  logic        prev_taken_3,
    input  logic [31:0] target_3
`ifdef BRANCH_PREDICTOR_PERF_EN
    ,
    output logic [31:0] perf_lookups,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_mispredicts
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_WT  = ~(CNT_MAX >> 1);

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [CNT_W-1:0]   r_cnt    [ENTRIES];

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic             w_update;
    logic             w_unused_pc_bits;

    assign w_lk_idx = instructionPC_1[IDX_W+1:2];
    assign w_lk_tag = instructionPC_1[31:IDX_W+2];
    assign w_up_idx = instructionPC_3[IDX_W+1:2];
    assign w_up_tag = instructionPC_3[31:IDX_W+2];
    assign w_unused_pc_bits = ^{instructionPC_1[1:0], instructionPC_3[1:0]};

    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_update = is_branchInst_3 && !memory_stall;

    always_comb begin
        taken    = w_lk_hit && r_cnt[w_lk_idx][CNT_W-1];
        flush    = is_branchInst_3 && (taken_3 != prev_taken_3);
        branchPC = instructionPC_1 + 32'd4;
        if (flush) begin
            branchPC = taken_3 ? target_3 : (instructionPC_3 + 32'd4);
        end else if (taken) begin
            branchPC = r_target[w_lk_idx];
        end
    end

    // Reads above see pre-edge contents, so a same-cycle update shows up next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_cnt[IDX_W'(i)] <= '0;
            end
        end else if (w_update) begin
            if (w_up_hit) begin
                if (taken_3) begin
                    r_target[w_up_idx] <= target_3;
                    if (r_cnt[w_up_idx] != CNT_MAX) begin
                        r_cnt[w_up_idx] <= r_cnt[w_up_idx] + 1'b1;
                    end
                end else if (r_cnt[w_up_idx] != '0) begin
                    r_cnt[w_up_idx] <= r_cnt[w_up_idx] - 1'b1;
                end
            end else if (taken_3) begin
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= target_3;
                r_cnt[w_up_idx]    <= CNT_WT;
            end
        end
    end

`ifdef BRANCH_PREDICTOR_PERF_EN
    logic [31:0] r_perf_lookups;
    logic [31:0] r_perf_hits;
    logic [31:0] r_perf_mispredicts;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_lookups     <= '0;
            r_perf_hits        <= '0;
            r_perf_mispredicts <= '0;
        end else if (!memory_stall) begin
            if (r_perf_lookups != '1) begin
                r_perf_lookups <= r_perf_lookups + 32'd1;
            end
            if (taken && (r_perf_hits != '1)) begin
                r_perf_hits <= r_perf_hits + 32'd1;
            end
            if (flush && (r_perf_mispredicts != '1)) begin
                r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
            end
        end
    end

    assign perf_lookups     = r_perf_lookups;
    assign perf_hits        = r_perf_hits;
    assign perf_mispredicts = r_perf_mispredicts;
`endif

endmodule

// File: tb/tb_branch_predictor_param.sv
// Scoreboard bench for branch_predictor_param: directed scenarios then random traffic
// checked against a table-of-records reference model.
module tb_branch_predictor_param;

    localparam int unsigned ENTRIES = 32;
    localparam int unsigned CNT_W   = 2;
    localparam int          CMAX    = (1 << CNT_W) - 1;
    localparam int          CTHR    = 1 << (CNT_W - 1);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memory_stall;
    logic [31:0] instructionPC_1;
    logic        taken;
    logic [31:0] branchPC;
    logic        flush;
    logic [31:0] instructionPC_3;
    logic        is_branchInst_3;
    logic        taken_3;
    logic        prev_taken_3;
    logic [31:0] target_3;
`ifdef BRANCH_PREDICTOR_PERF_EN
    logic [31:0] perf_lookups;
    logic [31:0] perf_hits;
    logic [31:0] perf_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_predictor_param #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .memory_stall    (memory_stall),
        .instructionPC_1 (instructionPC_1),
        .taken           (taken),
        .branchPC        (branchPC),
        .flush           (flush),
        .instructionPC_3 (instructionPC_3),
        .is_branchInst_3 (is_branchInst_3),
        .taken_3         (taken_3),
        .prev_taken_3    (prev_taken_3),
        .target_3        (target_3)
`ifdef BRANCH_PREDICTOR_PERF_EN
        ,
        .perf_lookups    (perf_lookups),
        .perf_hits       (perf_hits),
        .perf_mispredicts(perf_mispredicts)
`endif
    );

    typedef struct {
        bit          valid;
        int unsigned tag;
        logic [31:0] target;
        int          cnt;
    } ent_t;

    typedef struct {
        string       name;
        logic        taken;
        logic [31:0] bpc;
        logic        flush;
    } exp_t;

    ent_t        m[ENTRIES];
    exp_t        q[$];
    int          passed = 0;
    int          total  = 0;
    longint      m_lookups = 0, m_hits = 0, m_mis = 0;

    function automatic int unsigned idx_of(logic [31:0] pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: the predictor is combinational, so each cycle with a pending expectation is compared.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check({e.name, ".taken"}, {31'd0, taken}, {31'd0, e.taken});
            check({e.name, ".branchPC"}, branchPC, e.bpc);
            check({e.name, ".flush"}, {31'd0, flush}, {31'd0, e.flush});
        end
    end

    // Called just after a rising edge: drives one cycle, predicts outputs, then advances the model.
    task automatic drive(string name, bit rst, bit stall, logic [31:0] pc1, bit br,
                         logic [31:0] pc3, bit t3, bit pt3, logic [31:0] tgt3);
        int unsigned li, ui;
        bit          hit, ptaken, fl;
        exp_t        e;
        rst_n = rst; memory_stall = stall; instructionPC_1 = pc1;
        is_branchInst_3 = br; instructionPC_3 = pc3; taken_3 = t3;
        prev_taken_3 = pt3; target_3 = tgt3;
        li     = idx_of(pc1);
        hit    = m[li].valid && (m[li].tag == tag_of(pc1));
        ptaken = hit && (m[li].cnt >= CTHR);
        fl     = br && (t3 != pt3);
        e.name  = name;
        e.taken = ptaken;
        e.flush = fl;
        e.bpc   = fl ? (t3 ? tgt3 : pc3 + 32'd4) : (ptaken ? m[li].target : pc1 + 32'd4);
        if (rst) q.push_back(e);
        @(posedge clk);
        if (!rst) begin
            foreach (m[i]) begin m[i].valid = 0; m[i].cnt = 0; end
            m_lookups = 0; m_hits = 0; m_mis = 0;
        end else begin
            if (!stall) begin
                m_lookups++; m_hits += ptaken; m_mis += fl;
            end
            if (br && !stall) begin
                ui = idx_of(pc3);
                if (m[ui].valid && m[ui].tag == tag_of(pc3)) begin
                    if (t3) begin
                        m[ui].target = tgt3;
                        if (m[ui].cnt < CMAX) m[ui].cnt++;
                    end else if (m[ui].cnt > 0) m[ui].cnt--;
                end else if (t3) begin
                    m[ui].valid = 1; m[ui].tag = tag_of(pc3);
                    m[ui].target = tgt3; m[ui].cnt = CTHR;
                end
            end
        end
        #1;
    endtask

    task automatic look(string name, logic [31:0] pc1);
        drive(name, 1, 0, pc1, 0, 32'h0, 0, 0, 32'h0);
    endtask

    task automatic upd(string name, logic [31:0] pc1, logic [31:0] pc3, bit t3, bit pt3,
                       logic [31:0] tgt3);
        drive(name, 1, 0, pc1, 1, pc3, t3, pt3, tgt3);
    endtask

    localparam logic [31:0] ALIAS = 32'h100 + 4 * ENTRIES;

    initial begin
        logic [31:0] pc1, pc3;
        rst_n = 1'b0; memory_stall = 1'b0; instructionPC_1 = '0; is_branchInst_3 = 1'b0;
        instructionPC_3 = '0; taken_3 = 1'b0; prev_taken_3 = 1'b0; target_3 = '0;
        @(posedge clk); #1;
        drive("rst", 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
        drive("rst", 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);

        look("reset_lookup", 32'h100);
        upd("alloc_flush", 32'h100, 32'h100, 1, 0, 32'h200);
        look("alloc_hit", 32'h100);
        upd("dec1", 32'h100, 32'h100, 0, 1, 32'h0);
        upd("dec2", 32'h100, 32'h100, 0, 1, 32'h0);
        look("cnt0", 32'h100);
        upd("dec_sat1", 32'h100, 32'h100, 0, 0, 32'h0);
        upd("dec_sat2", 32'h100, 32'h100, 0, 0, 32'h0);
        upd("inc1", 32'h100, 32'h100, 1, 0, 32'h240);
        look("cnt1_not_taken", 32'h100);
        upd("inc2", 32'h100, 32'h100, 1, 1, 32'h250);
        look("cnt2_new_target", 32'h100);
        upd("alias_evict", 32'h100, ALIAS, 1, 0, 32'h300);
        look("evicted_lookup", 32'h100);
        look("alias_lookup", ALIAS);
        drive("stall_update", 1, 1, ALIAS, 1, ALIAS, 0, 1, 32'h0);
        drive("stall_update2", 1, 1, ALIAS, 1, ALIAS, 0, 1, 32'h0);
        look("after_stall", ALIAS);
        upd("same_cycle", ALIAS, ALIAS, 0, 1, 32'h0);
        look("after_same_cycle", ALIAS);
        drive("mid_reset", 0, 0, 32'h140, 1, 32'h140, 1, 0, 32'h400);
        look("post_reset_140", 32'h140);
        look("post_reset_alias", ALIAS);

        for (int n = 0; n < 600; n++) begin
            pc1 = 32'h1000 + 4 * $urandom_range(0, 3 * ENTRIES - 1);
            pc3 = 32'h1000 + 4 * $urandom_range(0, 3 * ENTRIES - 1);
            drive("rand", ($urandom_range(0, 99) != 0), ($urandom_range(0, 3) == 0), pc1,
                  ($urandom_range(0, 2) != 0), pc3, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC);
        end

`ifdef BRANCH_PREDICTOR_PERF_EN
        check("perf_lookups", perf_lookups, 32'(m_lookups));
        check("perf_hits", perf_hits, 32'(m_hits));
        check("perf_mispredicts", perf_mispredicts, 32'(m_mis));
`endif

        for (int w = 0; w < 4 && q.size() > 0; w++) @(negedge clk);
        if (q.size() > 0) begin
            total++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
